dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder on the core's data-memory port: accepts address/MemWrite/WriteData/byte_enable
//  from the pipelined RISC-V core and returns ReadData. Holds a byte-writable word RAM and a
//  small MMIO timer block (64-bit mtime/mtimecmp, prescaler, interrupt). Sits beside the core
//  at SoC top; ReadData is registered to line up with the core's M->W pipeline register.
// PARAMETERS
//  DMEM_BASE  32'h2000_0000  byte base address of RAM region
//  DEPTH      1024           RAM size in 32-bit words (power of 2)
//  MMIO_BASE  32'h4000_0000  byte base of timer register block (32 bytes decoded)
//  PRESCALE   1              clk cycles per mtime increment (>=1)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  n_rst        in   1   asynchronous active-low reset
//  MemWrite     in   1   write strobe for current address
//  ALUResult    in   32  byte address; [1:0] ignored (word access)
//  WriteData    in   32  store data, lane i = [8i+7:8i]
//  byte_enable  in   4   per-lane write enable, used only when MemWrite=1
//  ReadData     out  32  read word, registered
//  timer_irq    out  1   level interrupt = irq_pending & ctrl.ie
//  addr_err     out  1   one-cycle pulse: previous access hit unmapped address
// BEHAVIOUR
//  Reset: ReadData=0, addr_err=0, timer_irq=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF,
//   ctrl=0, prescaler=0. RAM contents not reset (X in sim).
//  Decode: RAM hit if DMEM_BASE <= addr < DMEM_BASE+4*DEPTH, index = (addr-DMEM_BASE)>>2.
//   MMIO hit if addr[31:5]==MMIO_BASE[31:5]. Else unmapped.
//  Read: every cycle, ReadData <= word at decoded address (1-cycle latency, no strobe).
//   Read-first: write and read of same word in one cycle returns OLD data; new data next cycle.
//   Unmapped -> ReadData<=0. Reads have no side effects.
//  RAM write: MemWrite=1 -> lanes with byte_enable[i]=1 updated; byte_enable=0 is no-op.
//  MMIO map (offset): 0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo, 0x0C mtimecmp_hi,
//   0x10 ctrl {bit0 en, bit1 ie, bit2 pending (RO, W1C)}, 0x14-0x1C read 0, writes ignored.
//   MMIO writes honour byte_enable per lane as for RAM (ctrl bit2 cleared by 1 in lane0 bit2).
//  Prescaler: when ctrl.en, counts 0..PRESCALE-1; on PRESCALE-1 wraps to 0 and mtime+=1.
//   ctrl.en=0 freezes prescaler and mtime. mtime wraps 2^64-1 -> 0, no flag.
//  SW write to mtime_lo/hi takes priority over the increment in that cycle (written value wins
//   for written lanes; unwritten half keeps pre-increment value, no carry into it).
//  pending: set (sticky) in any cycle ctrl.en=1 and mtime >= mtimecmp (unsigned 64-bit,
//   compare on current registered values). Cleared only by W1C; set wins over simultaneous clear.
//  timer_irq registered from pending&ie: asserts 1 cycle after pending sets.
//  addr_err: registered, 1 cycle after any unmapped access with MemWrite=1 OR any cycle
//   addressing unmapped space with byte_enable!=0; deasserts next cycle unless repeated.
//  Reset mid-operation: all registers return to reset values immediately; RAM kept.
// TESTING
//  RAM word: write 0xDEADBEEF @0x2000_0010 be=1111, read same -> ReadData=0xDEADBEEF next cycle.
//  Byte lanes: preload 0x11223344, write 0xAABBCCDD be=0101 -> read 0x11BB33DD.
//  Read-first: write 0x5 and read @0x2000_0000 same cycle (old 0x0) -> 0x0, following cycle 0x5.
//  Timer: PRESCALE=1, mtimecmp=10, ctrl=0b011 -> pending set when mtime=10, timer_irq high
//   next cycle; W1C ctrl=0b111 with mtimecmp=~0 -> irq drops.
//  Wrap/priority: mtime_lo=0xFFFF_FFFF, hi=0 -> after one tick hi=1, lo=0; write lo same cycle
//   as tick -> written value held, hi unchanged.
//  Unmapped: write @0x3000_0000 be=1111 -> addr_err pulse 1 cycle, ReadData=0, RAM unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined core: byte-writable word RAM plus a
// 64-bit mtime/mtimecmp timer block, with registered read data and error pulse.
module dmem_responder #(
  parameter logic [31:0] DMEM_BASE = 32'h2000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [3:0]  byte_enable,
  output logic [31:0] ReadData,
  output logic        timer_irq,
  output logic        addr_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    R_MTIME_LO = 3'd0,
    R_MTIME_HI = 3'd1,
    R_CMP_LO   = 3'd2,
    R_CMP_HI   = 3'd3,
    R_CTRL     = 3'd4,
    R_RSV5     = 3'd5,
    R_RSV6     = 3'd6,
    R_RSV7     = 3'd7
  } regSel_e;

  logic [31:0]   mem [DEPTH];

  logic [63:0]   mtime, mtimeNext;
  logic [63:0]   mtimecmp, cmpNext;
  logic [PW-1:0] prescaler, preNext;
  logic          ctrlEn, ctrlEnNext;
  logic          ctrlIe, ctrlIeNext;
  logic          pending, pendNext;

  logic [31:0]   ramOff;
  logic [AW-1:0] ramIdx;
  logic          ramHit, mmioHit, unmapped;
  regSel_e       regSel;
  logic          anyBe, mmioWr;
  logic          wrMtLo, wrMtHi, wrCmpLo, wrCmpHi, wrCtrl;
  logic          tick, pendSet, pendClr;
  logic [31:0]   mmioRd, rdNext;
  logic          errNext;

  function automatic logic [31:0] laneMerge(input logic [31:0] old,
                                            input logic [31:0] d,
                                            input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    ramOff   = ALUResult - DMEM_BASE;
    ramHit   = (ALUResult >= DMEM_BASE) && (ramOff < RAM_BYTES);
    ramIdx   = ramOff[AW+1:2];
    mmioHit  = (ALUResult[31:5] == MMIO_BASE[31:5]);
    unmapped = !ramHit && !mmioHit;
    regSel   = regSel_e'(ALUResult[4:2]);
    anyBe    = |byte_enable;
    mmioWr   = MemWrite && mmioHit && anyBe;

    wrMtLo  = mmioWr && (regSel == R_MTIME_LO);
    wrMtHi  = mmioWr && (regSel == R_MTIME_HI);
    wrCmpLo = mmioWr && (regSel == R_CMP_LO);
    wrCmpHi = mmioWr && (regSel == R_CMP_HI);
    wrCtrl  = mmioWr && (regSel == R_CTRL) && byte_enable[0];

    tick    = ctrlEn && (prescaler == PRE_LAST);
    preNext = prescaler;
    if (ctrlEn) preNext = tick ? '0 : prescaler + PW'(1);

    // A software write to either mtime half suppresses this cycle's increment,
    // so the other half keeps its pre-increment value and no carry crosses.
    mtimeNext = mtime;
    if (wrMtLo || wrMtHi) begin
      if (wrMtLo) mtimeNext[31:0]  = laneMerge(mtime[31:0],  WriteData, byte_enable);
      if (wrMtHi) mtimeNext[63:32] = laneMerge(mtime[63:32], WriteData, byte_enable);
    end else if (tick) begin
      mtimeNext = mtime + 64'd1;
    end

    cmpNext = mtimecmp;
    if (wrCmpLo) cmpNext[31:0]  = laneMerge(mtimecmp[31:0],  WriteData, byte_enable);
    if (wrCmpHi) cmpNext[63:32] = laneMerge(mtimecmp[63:32], WriteData, byte_enable);

    ctrlEnNext = wrCtrl ? WriteData[0] : ctrlEn;
    ctrlIeNext = wrCtrl ? WriteData[1] : ctrlIe;
    pendSet    = ctrlEn && (mtime >= mtimecmp);
    pendClr    = wrCtrl && WriteData[2];
    pendNext   = pendSet || (pending && !pendClr);

    unique case (regSel)
      R_MTIME_LO: mmioRd = mtime[31:0];
      R_MTIME_HI: mmioRd = mtime[63:32];
      R_CMP_LO:   mmioRd = mtimecmp[31:0];
      R_CMP_HI:   mmioRd = mtimecmp[63:32];
      R_CTRL:     mmioRd = {29'd0, pending, ctrlIe, ctrlEn};
      default:    mmioRd = '0;
    endcase

    rdNext = '0;
    if (ramHit)       rdNext = mem[ramIdx];
    else if (mmioHit) rdNext = mmioRd;

    errNext = unmapped && (MemWrite || anyBe);
  end

  // RAM array is deliberately left out of reset; reads sample the old word.
  always_ff @(posedge clk) begin
    if (MemWrite && ramHit)
      for (int unsigned i = 0; i < 4; i++)
        if (byte_enable[i]) mem[ramIdx][8*i +: 8] <= WriteData[8*i +: 8];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ReadData  <= '0;
      addr_err  <= 1'b0;
      timer_irq <= 1'b0;
      mtime     <= '0;
      mtimecmp  <= '1;
      prescaler <= '0;
      ctrlEn    <= 1'b0;
      ctrlIe    <= 1'b0;
      pending   <= 1'b0;
    end else begin
      ReadData  <= rdNext;
      addr_err  <= errNext;
      timer_irq <= pending && ctrlIe;
      mtime     <= mtimeNext;
      mtimecmp  <= cmpNext;
      prescaler <= preNext;
      ctrlEn    <= ctrlEnNext;
      ctrlIe    <= ctrlIeNext;
      pending   <= pendNext;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: read results go through an expectation
// queue and are checked when the registered ReadData appears.
module tb_dmem_responder;

  localparam logic [31:0] RAM  = 32'h2000_0000;
  localparam logic [31:0] MMIO = 32'h4000_0000;
  localparam logic [31:0] MT_LO = MMIO + 32'h00;
  localparam logic [31:0] MT_HI = MMIO + 32'h04;
  localparam logic [31:0] CM_LO = MMIO + 32'h08;
  localparam logic [31:0] CM_HI = MMIO + 32'h0C;
  localparam logic [31:0] CTRL  = MMIO + 32'h10;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [3:0]  byte_enable;
  logic [31:0] ReadData;
  logic        timer_irq;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] expQ[$];
  string       tagQ[$];

  dmem_responder #(
    .DMEM_BASE(RAM),
    .DEPTH(1024),
    .MMIO_BASE(MMIO),
    .PRESCALE(1)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .MemWrite(MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .byte_enable(byte_enable),
    .ReadData(ReadData),
    .timer_irq(timer_irq),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One bus cycle; when chk is set the expected read word is queued and
  // compared once the registered ReadData has updated.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit chk, input logic [31:0] exp,
                      input string tag);
    logic [31:0] e;
    string       t;
    MemWrite    = w;
    ALUResult   = a;
    WriteData   = d;
    byte_enable = be;
    if (chk) begin
      expQ.push_back(exp);
      tagQ.push_back(tag);
    end
    @(posedge clk);
    #1;
    MemWrite    = 1'b0;
    byte_enable = 4'b0000;
    ALUResult   = RAM;
    if (chk) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      check(t, ReadData, e);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, a, d, be, 1'b0, '0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    step(1'b0, a, '0, 4'b0000, 1'b1, exp, tag);
  endtask

  initial begin
    int n;
    n_rst       = 1'b0;
    MemWrite    = 1'b0;
    ALUResult   = RAM;
    WriteData   = '0;
    byte_enable = 4'b0000;
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    #1;
    check("rst_rdata", ReadData, 32'h0);
    check("rst_err", {31'd0, addr_err}, 32'h0);
    check("rst_irq", {31'd0, timer_irq}, 32'h0);
    rd(MT_LO, 32'h0, "rst_mtime_lo");
    rd(CM_LO, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(CM_HI, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(CTRL, 32'h0, "rst_ctrl");

    wr(RAM + 32'h10, 32'hDEAD_BEEF, 4'b1111);
    rd(RAM + 32'h10, 32'hDEAD_BEEF, "ram_word");

    wr(RAM + 32'h20, 32'h1122_3344, 4'b1111);
    wr(RAM + 32'h20, 32'hAABB_CCDD, 4'b0101);
    rd(RAM + 32'h20, 32'h11BB_33DD, "byte_lanes");
    wr(RAM + 32'h20, 32'h9999_9999, 4'b0000);
    rd(RAM + 32'h20, 32'h11BB_33DD, "be_zero_noop");
    rd(RAM + 32'hFFC, 32'hxxxx_xxxx, "ram_top_uninit");
    wr(RAM + 32'hFFC, 32'h0BAD_F00D, 4'b1111);
    rd(RAM + 32'hFFC, 32'h0BAD_F00D, "ram_top_word");

    wr(RAM, 32'h0, 4'b1111);
    step(1'b1, RAM, 32'h5, 4'b1111, 1'b1, 32'h0, "read_first_old");
    rd(RAM, 32'h5, "read_first_new");

    step(1'b1, 32'h3000_0000, 32'h1234_5678, 4'b1111, 1'b1, 32'h0, "unmapped_rdata");
    check("unmapped_err_pulse", {31'd0, addr_err}, 32'h1);
    rd(RAM + 32'h10, 32'hDEAD_BEEF, "unmapped_ram_kept");
    check("unmapped_err_drop", {31'd0, addr_err}, 32'h0);
    step(1'b0, RAM + 32'h1000, '0, 4'b0010, 1'b1, 32'h0, "ram_end_unmapped");
    check("unmapped_be_err", {31'd0, addr_err}, 32'h1);
    step(1'b0, 32'h3000_0000, '0, 4'b0000, 1'b0, '0, "");
    check("unmapped_quiet_read", {31'd0, addr_err}, 32'h0);

    wr(MMIO + 32'h14, 32'hFFFF_FFFF, 4'b1111);
    rd(MMIO + 32'h14, 32'h0, "reserved_reg");
    check("mmio_no_err", {31'd0, addr_err}, 32'h0);

    // Timer: compare at 10, counting starts the cycle after ctrl is written.
    wr(CM_LO, 32'd10, 4'b1111);
    wr(CM_HI, 32'd0, 4'b1111);
    wr(CTRL, 32'h3, 4'b0001);
    n = 0;
    while (n < 40 && timer_irq !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("irq_latency", n, 32'd12);
    rd(CTRL, 32'h7, "ctrl_pending");
    rd(MT_HI, 32'h0, "mtime_hi_running");

    wr(CM_LO, 32'hFFFF_FFFF, 4'b1111);
    wr(CM_HI, 32'hFFFF_FFFF, 4'b1111);
    wr(CTRL, 32'h7, 4'b0001);
    check("irq_after_w1c_edge", {31'd0, timer_irq}, 32'h1);
    @(posedge clk);
    #1;
    check("irq_dropped", {31'd0, timer_irq}, 32'h0);
    rd(CTRL, 32'h3, "ctrl_cleared");
    wr(CTRL, 32'h0, 4'b0001);

    // Software write to mtime_lo during a tick: no increment, no carry.
    wr(MT_LO, 32'hFFFF_FFFF, 4'b1111);
    wr(MT_HI, 32'h5, 4'b1111);
    wr(CTRL, 32'h1, 4'b0001);
    wr(MT_LO, 32'h7, 4'b1111);
    wr(CTRL, 32'h0, 4'b0001);
    rd(MT_LO, 32'h8, "prio_lo");
    rd(MT_HI, 32'h5, "prio_hi");

    wr(MT_LO, 32'hFFFF_FFFF, 4'b1111);
    wr(CTRL, 32'h1, 4'b0001);
    wr(CTRL, 32'h0, 4'b0001);
    rd(MT_LO, 32'h0, "wrap_lo");
    rd(MT_HI, 32'h6, "wrap_hi");
    rd(MT_LO, 32'h0, "frozen_lo");

    wr(CM_HI, 32'h1234_5678, 4'b0011);
    rd(CM_HI, 32'hFFFF_5678, "cmp_lanes");

    rd(RAM + 32'h10, 32'hDEAD_BEEF, "pre_reset_read");
    #3 n_rst = 1'b0;
    #1;
    check("async_rst_rdata", ReadData, 32'h0);
    @(posedge clk);
    #2 n_rst = 1'b1;
    rd(CM_HI, 32'hFFFF_FFFF, "reset_cmp_hi");
    rd(MT_HI, 32'h0, "reset_mtime_hi");
    rd(RAM + 32'h10, 32'hDEAD_BEEF, "reset_ram_kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want test completion");
    $fatal(1, "timeout");
  end

endmodule
